// File: rtl/udp_sched_pkg.sv
// rtl/udp_sched_pkg.sv - shared types and constants for the UDP port scheduler
package udp_sched_pkg;

  localparam int N_CLIENT = 7;
  localparam logic [1:0] CAT_UDP = 2'd3;
  localparam int PORT_MSB_PC_DEF = 36;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WAIT  = 3'd1,
    CAP   = 3'd2,
    MATCH = 3'd3,
    HOLD  = 3'd4
  } state_t;

endpackage

// File: rtl/port_cam_match.sv
// rtl/port_cam_match.sv - 7-way port compare with lowest-index priority
module port_cam_match
  import udp_sched_pkg::*;
(
  input  logic [15:0]                 port,
  input  logic [N_CLIENT-1:0][15:0]   port_tab,
  input  logic [N_CLIENT-1:0]         en,
  output logic [2:0]                  idx,
  output logic                        hit
);

  // Scan from the top down so the lowest matching entry is the last to win.
  always_comb begin
    idx = 3'd0;
    hit = 1'b0;
    for (int i = N_CLIENT - 1; i >= 0; i--) begin
      if (port_tab[i] != 16'd0 && port_tab[i] == port && en[i]) begin
        idx = 3'(i + 1);
        hit = 1'b1;
      end
    end
  end

endmodule

// File: rtl/udp_port_sched.sv
// rtl/udp_port_sched.sv - per-frame UDP destination-port client scheduler
// Optional miss counter (read back on hit_sel=0): define UDP_PORT_SCHED_MISS_EN.
module udp_port_sched
  import udp_sched_pkg::*;
#(
  parameter int port_msb_pc = PORT_MSB_PC_DEF,
  parameter int cnt_w       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       pc,
  input  logic [1:0]       category,
  input  logic [7:0]       idata,
  input  logic             eth_strobe_long,
  input  logic             cfg_we,
  input  logic [2:0]       cfg_addr,
  input  logic [15:0]      cfg_data,
  input  logic [6:0]       client_en,
  output logic [2:0]       udp_sel,
  output logic             sel_valid,
  output logic             cfg_pend,
  input  logic [2:0]       hit_sel,
  output logic [cnt_w-1:0] hit_cnt
);

  localparam logic [5:0]       PC_MSB = 6'(port_msb_pc);
  localparam logic [5:0]       PC_LSB = 6'(port_msb_pc + 1);
  localparam logic [cnt_w-1:0] ONE    = cnt_w'(1);
  localparam logic [cnt_w-1:0] SAT    = {cnt_w{1'b1}};

  state_t                    state;
  logic                      strobe_d;
  logic [7:0]                port_hi, port_lo;
  logic [N_CLIENT-1:0][15:0] port_tab;
  logic [2:0]                pend_addr;
  logic [15:0]               pend_data;
  logic [cnt_w-1:0]          cnt [N_CLIENT];
  logic [2:0]                m_idx;
  logic                      m_hit;
  logic                      udp_hit;
  logic                      to_idle;
  logic                      cfg_ok;
  logic                      wr_en;
  logic [2:0]                wr_addr;
  logic [15:0]               wr_data;

  port_cam_match u_cam (
    .port     ({port_hi, port_lo}),
    .port_tab (port_tab),
    .en       (client_en),
    .idx      (m_idx),
    .hit      (m_hit)
  );

  assign udp_hit = (category == CAT_UDP) && m_hit;
  assign to_idle = !eth_strobe_long && (state == WAIT || state == CAP || state == HOLD);
  assign cfg_ok  = cfg_we && (cfg_addr != 3'd0);

  // A write arriving on the commit edge itself supersedes the pending one.
  always_comb begin
    wr_en   = 1'b0;
    wr_addr = pend_addr;
    wr_data = pend_data;
    if (state == IDLE || (to_idle && cfg_ok)) begin
      wr_en   = cfg_ok;
      wr_addr = cfg_addr;
      wr_data = cfg_data;
    end else if (to_idle && cfg_pend) begin
      wr_en = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      strobe_d  <= 1'b0;
      port_hi   <= 8'd0;
      port_lo   <= 8'd0;
      udp_sel   <= 3'd0;
      sel_valid <= 1'b0;
    end else begin
      strobe_d <= eth_strobe_long;
      case (state)
        IDLE:
          if (eth_strobe_long && !strobe_d) state <= WAIT;
        WAIT:
          if (!eth_strobe_long) begin
            state <= IDLE;
          end else if (pc == PC_MSB) begin
            port_hi <= idata;
            state   <= CAP;
          end
        CAP:
          if (!eth_strobe_long) begin
            state <= IDLE;
          end else if (pc == PC_LSB) begin
            port_lo <= idata;
            state   <= MATCH;
          end
        MATCH: begin
          udp_sel   <= udp_hit ? m_idx : 3'd0;
          sel_valid <= 1'b1;
          state     <= HOLD;
        end
        HOLD:
          if (!eth_strobe_long) begin
            udp_sel   <= 3'd0;
            sel_valid <= 1'b0;
            state     <= IDLE;
          end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      port_tab  <= '0;
      cfg_pend  <= 1'b0;
      pend_addr <= 3'd0;
      pend_data <= 16'd0;
    end else begin
      for (int i = 0; i < N_CLIENT; i++) begin
        if (wr_en && wr_addr == 3'(i + 1)) port_tab[i] <= wr_data;
      end
      if (state == IDLE || to_idle) begin
        cfg_pend <= 1'b0;
      end else if (cfg_ok) begin
        cfg_pend  <= 1'b1;
        pend_addr <= cfg_addr;
        pend_data <= cfg_data;
      end
    end
  end

`ifdef UDP_PORT_SCHED_MISS_EN
  logic [cnt_w-1:0] miss_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      miss_cnt <= '0;
    end else if (state == MATCH && category == CAT_UDP && !m_hit && miss_cnt != SAT) begin
      miss_cnt <= miss_cnt + ONE;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_CLIENT; i++) cnt[i] <= '0;
    end else if (state == MATCH && udp_hit) begin
      for (int i = 0; i < N_CLIENT; i++) begin
        if (m_idx == 3'(i + 1) && cnt[i] != SAT) cnt[i] <= cnt[i] + ONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hit_cnt <= '0;
    end else begin
`ifdef UDP_PORT_SCHED_MISS_EN
      hit_cnt <= miss_cnt;
`else
      hit_cnt <= '0;
`endif
      for (int i = 0; i < N_CLIENT; i++) begin
        if (hit_sel == 3'(i + 1)) hit_cnt <= cnt[i];
      end
    end
  end

endmodule

// File: tb/tb_udp_port_sched.sv
// tb/tb_udp_port_sched.sv - directed self-checking bench for udp_port_sched
module tb_udp_port_sched;
  import udp_sched_pkg::*;

  localparam int CNT_W = 4;

  logic             clk;
  logic             rst;
  logic [5:0]       pc;
  logic [1:0]       category;
  logic [7:0]       idata;
  logic             eth_strobe_long;
  logic             cfg_we;
  logic [2:0]       cfg_addr;
  logic [15:0]      cfg_data;
  logic [6:0]       client_en;
  logic [2:0]       udp_sel;
  logic             sel_valid;
  logic             cfg_pend;
  logic [2:0]       hit_sel;
  logic [CNT_W-1:0] hit_cnt;

  int errors = 0;
  int checks = 0;

  int         first_valid;
  logic [2:0] first_sel;
  logic       stable;
  logic       pend_seen;
  logic       rst_sv;
  logic [2:0] rst_sel;
  logic       rst_idle;
  logic [2:0] sel_last;
  logic       sv_last;
  logic       post_sv;
  logic [2:0] post_sel;
  logic       post_pend;
  logic [CNT_W-1:0] rd;

  udp_port_sched #(.port_msb_pc(36), .cnt_w(CNT_W)) dut (
    .clk             (clk),
    .rst             (rst),
    .pc              (pc),
    .category        (category),
    .idata           (idata),
    .eth_strobe_long (eth_strobe_long),
    .cfg_we          (cfg_we),
    .cfg_addr        (cfg_addr),
    .cfg_data        (cfg_data),
    .client_en       (client_en),
    .udp_sel         (udp_sel),
    .sel_valid       (sel_valid),
    .cfg_pend        (cfg_pend),
    .hit_sel         (hit_sel),
    .hit_cnt         (hit_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cfg_write(input logic [2:0] a, input logic [15:0] d);
    cfg_we = 1'b1; cfg_addr = a; cfg_data = d;
    @(posedge clk); #1;
    cfg_we = 1'b0;
  endtask

  task automatic read_cnt(input logic [2:0] s);
    hit_sel = s;
    @(posedge clk); #1;
    rd = hit_cnt;
  endtask

  // One frame of len bytes; optional config write at cfg_pc and reset pulse at rst_pc.
  task automatic run_frame(input logic [15:0] port, input logic [1:0] cat, input int len,
                           input int cfg_pc, input logic [2:0] cfg_a, input logic [15:0] cfg_d,
                           input int rst_pc);
    first_valid = -1; first_sel = 3'd0; stable = 1'b1; pend_seen = 1'b0;
    rst_sv = 1'b1; rst_sel = 3'd7; rst_idle = 1'b0;
    for (int p = 0; p < len; p++) begin
      pc = 6'(p);
      eth_strobe_long = 1'b1;
      category = cat;
      idata = (p == 36) ? port[15:8] : (p == 37) ? port[7:0] : 8'(p);
      cfg_we = (p == cfg_pc); cfg_addr = cfg_a; cfg_data = cfg_d;
      rst = (p == rst_pc);
      @(posedge clk); #1;
      if (p == cfg_pc) pend_seen = cfg_pend;
      if (p == rst_pc) begin
        rst_sv = sel_valid; rst_sel = udp_sel; rst_idle = (dut.state == IDLE);
      end
      if (sel_valid === 1'b1) begin
        if (first_valid < 0) begin
          first_valid = p + 1; first_sel = udp_sel;
        end else if (udp_sel !== first_sel) begin
          stable = 1'b0;
        end
      end
    end
    cfg_we = 1'b0; rst = 1'b0;
    sel_last = udp_sel; sv_last = sel_valid;
    eth_strobe_long = 1'b0; pc = 6'd0; idata = 8'd0;
    @(posedge clk); #1;
    post_sv = sel_valid; post_sel = udp_sel; post_pend = cfg_pend;
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; hit_sel = 3'd0;
    repeat (2) @(posedge clk);
    #1; rst = 1'b0;
    checks++; if (udp_sel !== 3'd0) begin errors++; $display("FAIL reset_udp_sel: got %0d expected 0", udp_sel); end
    checks++; if (sel_valid !== 1'b0) begin errors++; $display("FAIL reset_sel_valid: got %0b expected 0", sel_valid); end
    checks++; if (cfg_pend !== 1'b0) begin errors++; $display("FAIL reset_cfg_pend: got %0b expected 0", cfg_pend); end
    checks++; if (hit_cnt !== 4'd0) begin errors++; $display("FAIL reset_hit_cnt: got %0d expected 0", hit_cnt); end
  endtask

  task automatic test_basic;
    cfg_write(3'd3, 16'h1234);
    checks++; if (cfg_pend !== 1'b0) begin errors++; $display("FAIL basic_idle_write_pend: got %0b expected 0", cfg_pend); end
    run_frame(16'h1234, 2'd3, 48, -1, 3'd0, 16'd0, -1);
    checks++; if (first_valid != 39) begin errors++; $display("FAIL basic_valid_pc: got %0d expected 39", first_valid); end
    checks++; if (sel_last !== 3'd3) begin errors++; $display("FAIL basic_udp_sel: got %0d expected 3", sel_last); end
    checks++; if (sv_last !== 1'b1 || stable !== 1'b1) begin errors++; $display("FAIL basic_held: got valid=%0b stable=%0b expected 1 1", sv_last, stable); end
    checks++; if (post_sv !== 1'b0 || post_sel !== 3'd0) begin errors++; $display("FAIL basic_frame_end: got valid=%0b sel=%0d expected 0 0", post_sv, post_sel); end
    read_cnt(3'd3);
    checks++; if (rd !== 4'd1) begin errors++; $display("FAIL basic_hit_cnt3: got %0d expected 1", rd); end
  endtask

  task automatic test_priority;
    cfg_write(3'd2, 16'h0BB8);
    cfg_write(3'd5, 16'h0BB8);
    run_frame(16'h0BB8, 2'd3, 48, -1, 3'd0, 16'd0, -1);
    checks++; if (sel_last !== 3'd2) begin errors++; $display("FAIL prio_lowest: got %0d expected 2", sel_last); end
    client_en = 7'h7D;
    run_frame(16'h0BB8, 2'd3, 48, -1, 3'd0, 16'd0, -1);
    checks++; if (sel_last !== 3'd5) begin errors++; $display("FAIL prio_disabled: got %0d expected 5", sel_last); end
    client_en = 7'h7F;
    read_cnt(3'd2);
    checks++; if (rd !== 4'd1) begin errors++; $display("FAIL prio_cnt2: got %0d expected 1", rd); end
    read_cnt(3'd5);
    checks++; if (rd !== 4'd1) begin errors++; $display("FAIL prio_cnt5: got %0d expected 1", rd); end
  endtask

  task automatic test_non_udp;
    run_frame(16'h1234, 2'd2, 48, -1, 3'd0, 16'd0, -1);
    checks++; if (first_valid != 39) begin errors++; $display("FAIL nonudp_valid_pc: got %0d expected 39", first_valid); end
    checks++; if (sel_last !== 3'd0) begin errors++; $display("FAIL nonudp_udp_sel: got %0d expected 0", sel_last); end
    read_cnt(3'd3);
    checks++; if (rd !== 4'd1) begin errors++; $display("FAIL nonudp_cnt3: got %0d expected 1", rd); end
    read_cnt(3'd0);
    checks++; if (rd !== 4'd0) begin errors++; $display("FAIL nonudp_miss_rd: got %0d expected 0", rd); end
  endtask

  task automatic test_miss;
    run_frame(16'h9999, 2'd3, 48, -1, 3'd0, 16'd0, -1);
    checks++; if (sel_last !== 3'd0 || sv_last !== 1'b1) begin errors++; $display("FAIL miss_sel: got sel=%0d valid=%0b expected 0 1", sel_last, sv_last); end
    read_cnt(3'd0);
`ifdef UDP_PORT_SCHED_MISS_EN
    checks++; if (rd !== 4'd1) begin errors++; $display("FAIL miss_cnt: got %0d expected 1", rd); end
`else
    checks++; if (rd !== 4'd0) begin errors++; $display("FAIL miss_cnt: got %0d expected 0", rd); end
`endif
  endtask

  task automatic test_pending;
    run_frame(16'h0050, 2'd3, 48, 20, 3'd1, 16'h0050, -1);
    checks++; if (pend_seen !== 1'b1) begin errors++; $display("FAIL pend_set: got %0b expected 1", pend_seen); end
    checks++; if (sel_last !== 3'd0) begin errors++; $display("FAIL pend_old_table: got %0d expected 0", sel_last); end
    checks++; if (post_pend !== 1'b0) begin errors++; $display("FAIL pend_commit: got %0b expected 0", post_pend); end
    run_frame(16'h0050, 2'd3, 48, -1, 3'd0, 16'd0, -1);
    checks++; if (sel_last !== 3'd1) begin errors++; $display("FAIL pend_new_table: got %0d expected 1", sel_last); end
  endtask

  task automatic test_short_frame;
    run_frame(16'h1234, 2'd3, 30, -1, 3'd0, 16'd0, -1);
    checks++; if (first_valid != -1) begin errors++; $display("FAIL short_no_valid: got pc %0d expected none", first_valid); end
    checks++; if (sel_last !== 3'd0 || post_sel !== 3'd0) begin errors++; $display("FAIL short_sel: got %0d/%0d expected 0", sel_last, post_sel); end
    checks++; if (dut.state !== IDLE) begin errors++; $display("FAIL short_idle: got %0d expected %0d", dut.state, IDLE); end
    read_cnt(3'd3);
    checks++; if (rd !== 4'd1) begin errors++; $display("FAIL short_cnt3: got %0d expected 1", rd); end
    run_frame(16'h1234, 2'd3, 48, -1, 3'd0, 16'd0, -1);
    checks++; if (sel_last !== 3'd3) begin errors++; $display("FAIL short_next_frame: got %0d expected 3", sel_last); end
  endtask

  task automatic test_reset_in_hold;
    run_frame(16'h1234, 2'd3, 48, -1, 3'd0, 16'd0, 44);
    checks++; if (rst_sv !== 1'b0 || rst_sel !== 3'd0) begin errors++; $display("FAIL hold_rst_out: got valid=%0b sel=%0d expected 0 0", rst_sv, rst_sel); end
    checks++; if (rst_idle !== 1'b1) begin errors++; $display("FAIL hold_rst_idle: got %0b expected 1", rst_idle); end
    read_cnt(3'd3);
    checks++; if (rd !== 4'd0) begin errors++; $display("FAIL hold_rst_cnt: got %0d expected 0", rd); end
    cfg_write(3'd3, 16'h1234);
    run_frame(16'h1234, 2'd3, 48, -1, 3'd0, 16'd0, -1);
    checks++; if (sel_last !== 3'd3) begin errors++; $display("FAIL hold_rst_next: got %0d expected 3", sel_last); end
    read_cnt(3'd3);
    checks++; if (rd !== 4'd1) begin errors++; $display("FAIL hold_rst_next_cnt: got %0d expected 1", rd); end
  endtask

  task automatic test_saturation;
    cfg_write(3'd1, 16'h0050);
    for (int k = 0; k < 14; k++) run_frame(16'h0050, 2'd3, 48, -1, 3'd0, 16'd0, -1);
    read_cnt(3'd1);
    checks++; if (rd !== 4'd14) begin errors++; $display("FAIL sat_pre: got %0d expected 14", rd); end
    for (int k = 0; k < 3; k++) run_frame(16'h0050, 2'd3, 48, -1, 3'd0, 16'd0, -1);
    read_cnt(3'd1);
    checks++; if (rd !== 4'hF) begin errors++; $display("FAIL sat_hold: got %0d expected 15", rd); end
  endtask

  initial begin
    rst = 1'b1; pc = 6'd0; category = 2'd0; idata = 8'd0; eth_strobe_long = 1'b0;
    cfg_we = 1'b0; cfg_addr = 3'd0; cfg_data = 16'd0; client_en = 7'h7F; hit_sel = 3'd0;
    test_reset();
    test_basic();
    test_priority();
    test_non_udp();
    test_miss();
    test_pending();
    test_short_frame();
    test_reset_in_hold();
    test_saturation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
